bsg_cache_dma_arbiter: RTL and testbench
========================================

Name: bsg_cache_dma_arbiter

Overview:
- Shares one bsg_cache DMA port among num_cache_p bsg_cache instances.
- Output port feeds a single DMA-to-AXI bridge or DRAM controller.
- Arbitrates DMA packets round-robin and records each grant in order.
- Routes fill data back to the requester that owns it, and forwards evict data from the requester that owns it.

Parameters:
- num_cache_p, 4, number of requesting caches (≥2).
- addr_width_p, 28, cache byte-address width.
- data_width_p, 32, DMA data word width.
- block_size_in_words_p, 8, words per DMA transaction (power of 2, ≥2).
- tag_fifo_els_p, 4, depth of each ordering FIFO (read and write).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- dma_pkt_i  in  num_cache_p x (addr_width_p+1)  per-cache packet; MSB = write_not_read, low bits = addr
- dma_pkt_v_i  in  num_cache_p  packet valid
- dma_pkt_yumi_o  out  num_cache_p  packet consumed
- dma_data_o  out  num_cache_p x data_width_p  fill data to caches (shared bus)
- dma_data_v_o  out  num_cache_p  fill valid, one-hot or zero
- dma_data_ready_i  in  num_cache_p  cache ready for fill
- dma_data_i  in  num_cache_p x data_width_p  evict data from caches
- dma_data_v_i  in  num_cache_p  evict valid
- dma_data_yumi_o  out  num_cache_p  evict consumed
- dma_pkt_o  out  addr_width_p+1  merged packet downstream
- dma_pkt_v_o  out  1  merged packet valid
- dma_pkt_yumi_i  in  1  downstream consumed packet
- mem_data_i  in  data_width_p  fill data from downstream
- mem_data_v_i  in  1  fill valid
- mem_data_ready_o  out  1  ready for fill
- mem_data_o  out  data_width_p  evict data downstream
- mem_data_v_o  out  1  evict valid
- mem_data_yumi_i  in  1  downstream consumed evict word

Behaviour:
- Reset:
  - All valid and yumi outputs are 0; mem_data_ready_o is 0.
  - Round-robin pointer is set so cache 0 has highest priority.
  - Both FIFOs are emptied and both word counters are 0.
  - Reset asserted mid-transaction abandons the transaction, with no partial output afterwards.
- Packet arbitration:
  - A requester i is eligible when dma_pkt_v_i[i]=1 and the FIFO its MSB selects is not full.
  - Priority starts at the index after the last granted index and wraps modulo num_cache_p.
  - dma_pkt_v_o=1 when any requester is eligible.
  - dma_pkt_o is the granted requester's packet, passed through unmodified (combinational).
- Grant lock:
  - After dma_pkt_v_o rises without dma_pkt_yumi_i, the grant is held until yumi.
  - While held, dma_pkt_o must not change even if a higher-priority requester becomes valid.
- Packet acceptance:
  - dma_pkt_yumi_o[g] = dma_pkt_yumi_i for the granted index g only, in the same cycle.
  - On yumi, the pointer is set to g.
  - On yumi, g is pushed into the read FIFO (MSB=0) or the write FIFO (MSB=1).
- Fill path (read FIFO head h, valid when read FIFO is non-empty):
  - mem_data_ready_o = rd_nonempty & dma_data_ready_i[h].
  - dma_data_v_o[h] = mem_data_v_i & rd_nonempty; all other bits are 0.
  - dma_data_o carries mem_data_i to every cache.
  - The fill counter increments on each mem_data_v_i & mem_data_ready_o.
  - At block_size_in_words_p-1 the counter wraps to 0 and the read FIFO pops.
- Evict path (write FIFO head w):
  - mem_data_v_o = wr_nonempty & dma_data_v_i[w], and mem_data_o = dma_data_i[w].
  - dma_data_yumi_o[w] = mem_data_yumi_i; all other bits are 0.
  - The evict counter counts mem_data_yumi_i, wraps at block_size_in_words_p-1 and pops the write FIFO.
- Ordering:
  - Reads return in grant order and writes drain in grant order.
  - The read and write paths are independent and may be active in the same cycle.
- Simultaneous events:
  - A push and pop of the same FIFO in one cycle are both legal.
  - A full FIFO accepts a push in a cycle where it pops, and its occupancy stays unchanged.
  - A packet for the same requester may be granted while that requester's earlier transaction is still streaming.
- Error checking:
  - Simulation-only assertions fire on mem_data_v_i with the read FIFO empty.
  - They also fire on dma_pkt_yumi_i without dma_pkt_v_o.
- Latency: 0 cycles for packets and data (combinational pass-through); the only state is the FIFOs, counters and pointer.

Test Plan:
- Arbitration order:
  - Stimulus: after reset, caches 0, 1 and 2 assert read packets to addr 0x100, 0x200 and 0x300; downstream yumis every cycle.
  - Required: grants in order 0, 1, 2; dma_pkt_o addr 0x100, 0x200, 0x300 on consecutive cycles; read FIFO holds {0,1,2}.
- Fill routing:
  - Stimulus: supply 24 fill words 0..23 after the first scenario.
  - Required: words 0-7 go only to cache 0, 8-15 to cache 1, 16-23 to cache 2; read FIFO ends empty.
- Fill backpressure:
  - Stimulus: dma_data_ready_i[1]=0 for 5 cycles mid-block.
  - Required: mem_data_ready_o=0 during those cycles; no words are dropped or duplicated; counter is held.
- Writeback:
  - Stimulus: cache 3 writes to addr 0x400 with data 0xA0..0xA7; mem_data_yumi_i toggles 1,0,1,0.
  - Required: 8 words appear in order; dma_data_yumi_o[3] matches mem_data_yumi_i; write FIFO pops after the 8th word.
- Grant lock and wrap:
  - Stimulus: cache 3 is granted; hold dma_pkt_yumi_i=0 for 3 cycles while cache 0 raises v.
  - Required: dma_pkt_o stays cache 3's packet; after yumi the next grant is cache 0.
- Full FIFO and reset:
  - Stimulus: issue 4 reads without fill; cache 1 then requests a 5th read.
  - Required: dma_pkt_v_o=0 for that request, and writes are still granted.
  - Stimulus: assert reset_i for 1 cycle.
  - Required: all outputs are 0; a subsequent read by cache 2 is granted first.

Source files
------------

// File: rtl/bsg_cache_dma_arbiter.sv
// Shares one bsg_cache DMA port among several caches: round-robin packet arbitration,
// with grant-ordered FIFOs that steer fill data back and pull evict data forward.

module bsg_cache_dma_arbiter_fifo #(
  parameter int els_p   = 4,
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               push_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] count_r;

  assign full_o  = (count_r == cnt_w_lp'(els_p));
  assign empty_o = (count_r == '0);
  assign data_o  = mem_r[rptr_r];

  // A full FIFO may push in the same cycle it pops; occupancy then stays put.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_i)
        wptr_r <= (wptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wptr_r + ptr_w_lp'(1);
      if (pop_i)
        rptr_r <= (rptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rptr_r + ptr_w_lp'(1);
      if (push_i && !pop_i)
        count_r <= count_r + cnt_w_lp'(1);
      else if (!push_i && pop_i)
        count_r <= count_r - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i)
      mem_r[wptr_r] <= data_i;
  end

endmodule

module bsg_cache_dma_arbiter #(
  parameter int num_cache_p           = 4,
  parameter int addr_width_p          = 28,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int tag_fifo_els_p        = 4
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_cache_p-1:0][addr_width_p:0]    dma_pkt_i,
  input  logic [num_cache_p-1:0]                    dma_pkt_v_i,
  output logic [num_cache_p-1:0]                    dma_pkt_yumi_o,
  output logic [num_cache_p-1:0][data_width_p-1:0]  dma_data_o,
  output logic [num_cache_p-1:0]                    dma_data_v_o,
  input  logic [num_cache_p-1:0]                    dma_data_ready_i,
  input  logic [num_cache_p-1:0][data_width_p-1:0]  dma_data_i,
  input  logic [num_cache_p-1:0]                    dma_data_v_i,
  output logic [num_cache_p-1:0]                    dma_data_yumi_o,
  output logic [addr_width_p:0]                     dma_pkt_o,
  output logic                                      dma_pkt_v_o,
  input  logic                                      dma_pkt_yumi_i,
  input  logic [data_width_p-1:0]                   mem_data_i,
  input  logic                                      mem_data_v_i,
  output logic                                      mem_data_ready_o,
  output logic [data_width_p-1:0]                   mem_data_o,
  output logic                                      mem_data_v_o,
  input  logic                                      mem_data_yumi_i
);

  localparam int lg_n_lp = $clog2(num_cache_p);
  localparam int lg_b_lp = $clog2(block_size_in_words_p);

  typedef enum logic {e_free, e_locked} arb_state_e;

  arb_state_e           arb_state_r;
  logic [lg_n_lp-1:0]   last_r, lock_idx_r, grant_idx, rr_sel, rd_head, wr_head;
  logic                 grant_v;
  logic [num_cache_p-1:0] eligible;
  logic                 rd_full, rd_empty, wr_full, wr_empty;
  logic                 rd_push, wr_push, rd_pop, wr_pop, fill_fire, evict_fire;
  logic [lg_b_lp-1:0]   fill_cnt_r, evict_cnt_r;

  assign fill_fire  = mem_data_v_i & mem_data_ready_o;
  assign evict_fire = ~wr_empty & mem_data_yumi_i;
  assign rd_pop     = fill_fire  & (fill_cnt_r  == lg_b_lp'(block_size_in_words_p - 1));
  assign wr_pop     = evict_fire & (evict_cnt_r == lg_b_lp'(block_size_in_words_p - 1));

  // A slot freed by this cycle's final word counts as room for a new packet.
  always_comb begin
    for (int i = 0; i < num_cache_p; i++)
      eligible[i] = dma_pkt_v_i[i] & (dma_pkt_i[i][addr_width_p] ? (~wr_full | wr_pop)
                                                                   : (~rd_full | rd_pop));
  end

  // Scanning from farthest to nearest leaves the nearest eligible index after last_r.
  always_comb begin
    grant_idx = last_r;
    grant_v   = 1'b0;
    rr_sel    = '0;
    if (arb_state_r == e_locked) begin
      grant_idx = lock_idx_r;
      grant_v   = eligible[lock_idx_r];
    end else begin
      for (int k = num_cache_p; k >= 1; k--) begin
        rr_sel = lg_n_lp'((int'(last_r) + k) % num_cache_p);
        if (eligible[rr_sel]) begin
          grant_idx = rr_sel;
          grant_v   = 1'b1;
        end
      end
    end
  end

  assign dma_pkt_v_o = grant_v;
  assign dma_pkt_o   = dma_pkt_i[grant_idx];
  assign rd_push     = dma_pkt_yumi_i & grant_v & ~dma_pkt_o[addr_width_p];
  assign wr_push     = dma_pkt_yumi_i & grant_v &  dma_pkt_o[addr_width_p];

  always_comb begin
    dma_pkt_yumi_o             = '0;
    dma_pkt_yumi_o[grant_idx]  = dma_pkt_yumi_i & grant_v;
    dma_data_v_o               = '0;
    dma_data_v_o[rd_head]      = mem_data_v_i & ~rd_empty;
    dma_data_yumi_o            = '0;
    dma_data_yumi_o[wr_head]   = mem_data_yumi_i & ~wr_empty;
  end

  assign dma_data_o       = {num_cache_p{mem_data_i}};
  assign mem_data_ready_o = ~rd_empty & dma_data_ready_i[rd_head];
  assign mem_data_v_o     = ~wr_empty & dma_data_v_i[wr_head];
  assign mem_data_o       = dma_data_i[wr_head];

  // An offered packet stays granted until downstream takes it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      arb_state_r <= e_free;
      last_r      <= lg_n_lp'(num_cache_p - 1);
      lock_idx_r  <= '0;
    end else if (grant_v) begin
      if (dma_pkt_yumi_i) begin
        arb_state_r <= e_free;
        last_r      <= grant_idx;
      end else begin
        arb_state_r <= e_locked;
        lock_idx_r  <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fill_cnt_r  <= '0;
      evict_cnt_r <= '0;
    end else begin
      if (fill_fire)
        fill_cnt_r  <= rd_pop ? '0 : fill_cnt_r + lg_b_lp'(1);
      if (evict_fire)
        evict_cnt_r <= wr_pop ? '0 : evict_cnt_r + lg_b_lp'(1);
    end
  end

  bsg_cache_dma_arbiter_fifo #(.els_p(tag_fifo_els_p), .width_p(lg_n_lp)) rd_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(grant_idx), .push_i(rd_push),
    .pop_i(rd_pop), .data_o(rd_head), .full_o(rd_full), .empty_o(rd_empty)
  );

  bsg_cache_dma_arbiter_fifo #(.els_p(tag_fifo_els_p), .width_p(lg_n_lp)) wr_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(grant_idx), .push_i(wr_push),
    .pop_i(wr_pop), .data_o(wr_head), .full_o(wr_full), .empty_o(wr_empty)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(mem_data_v_i && rd_empty));
      assert (!(dma_pkt_yumi_i && !dma_pkt_v_o));
    end
  end
`endif

endmodule

// File: tb/tb_bsg_cache_dma_arbiter.sv
// Bench for bsg_cache_dma_arbiter: directed scenarios plus a queue-based model
// that is compared against every output on each falling edge.

module tb_bsg_cache_dma_arbiter;

  localparam int N = 4, AW = 28, DW = 32, BLK = 8, DEPTH = 4;

  logic clk = 1'b0;
  logic reset_i;
  logic [N-1:0][AW:0]   dma_pkt_i;
  logic [N-1:0]         dma_pkt_v_i, dma_pkt_yumi_o;
  logic [N-1:0][DW-1:0] dma_data_o, dma_data_i;
  logic [N-1:0]         dma_data_v_o, dma_data_ready_i, dma_data_v_i, dma_data_yumi_o;
  logic [AW:0]          dma_pkt_o;
  logic                 dma_pkt_v_o, dma_pkt_yumi_i;
  logic [DW-1:0]        mem_data_i, mem_data_o;
  logic                 mem_data_v_i, mem_data_ready_o, mem_data_v_o, mem_data_yumi_i;

  int tests = 0, fails = 0;
  int rdq[$], wrq[$], grants[$], recv_q[$], wb_q[$];
  int last = N - 1, held = -1, fcnt = 0, ecnt = 0;

  bsg_cache_dma_arbiter #(
    .num_cache_p(N), .addr_width_p(AW), .data_width_p(DW),
    .block_size_in_words_p(BLK), .tag_fifo_els_p(DEPTH)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .dma_pkt_o(dma_pkt_o), .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_yumi_i(dma_pkt_yumi_i),
    .mem_data_i(mem_data_i), .mem_data_v_i(mem_data_v_i), .mem_data_ready_o(mem_data_ready_o),
    .mem_data_o(mem_data_o), .mem_data_v_o(mem_data_v_o), .mem_data_yumi_i(mem_data_yumi_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [AW:0] mkPkt(input bit wr, input int addr);
    return {wr, AW'(addr)};
  endfunction

  task automatic applyStimulus(input int c, input bit v, input bit wr, input int addr);
    dma_pkt_v_i[c] = v;
    dma_pkt_i[c]   = mkPkt(wr, addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: who may be granted this cycle, given queued grants and the current inputs.
  function automatic int modelGrant();
    bit rd_pop_now, wr_pop_now, ok;
    int i;
    rd_pop_now = rdq.size() > 0 && mem_data_v_i && dma_data_ready_i[rdq[0]] && fcnt == BLK - 1;
    wr_pop_now = wrq.size() > 0 && mem_data_yumi_i && ecnt == BLK - 1;
    for (int k = 0; k <= N; k++) begin
      if (k == 0) begin
        if (held < 0) continue;
        i = held;
      end else begin
        if (held >= 0) break;
        i = (last + k) % N;
      end
      ok = dma_pkt_v_i[i] && (dma_pkt_i[i][AW] ? (wrq.size() < DEPTH || wr_pop_now)
                                               : (rdq.size() < DEPTH || rd_pop_now));
      if (ok) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_update
    int g;
    bit rfire, efire;
    if (reset_i) begin
      rdq.delete(); wrq.delete();
      last = N - 1; held = -1; fcnt = 0; ecnt = 0;
    end else begin
      g     = modelGrant();
      rfire = rdq.size() > 0 && mem_data_v_i && dma_data_ready_i[rdq[0]];
      efire = wrq.size() > 0 && mem_data_yumi_i;
      if (rfire) begin
        if (fcnt == BLK - 1) begin fcnt = 0; void'(rdq.pop_front()); end
        else fcnt++;
      end
      if (efire) begin
        if (ecnt == BLK - 1) begin ecnt = 0; void'(wrq.pop_front()); end
        else ecnt++;
      end
      if (g >= 0) begin
        if (dma_pkt_yumi_i) begin
          if (dma_pkt_i[g][AW]) wrq.push_back(g);
          else rdq.push_back(g);
          last = g; held = -1;
          grants.push_back(g);
        end else begin
          held = g;
        end
      end
    end
  end

  always @(negedge clk) begin : compare_proc
    int g;
    bit any;
    logic [N-1:0] exp_yumi, exp_dv, exp_dy;
    bit exp_ready, exp_mv;
    if (!reset_i) begin
      g = modelGrant();
      exp_yumi = '0;
      if (g >= 0 && dma_pkt_yumi_i) exp_yumi[g] = 1'b1;
      checkOutput("pkt_v", 64'(dma_pkt_v_o), 64'(g >= 0));
      checkOutput("pkt_yumi", 64'(dma_pkt_yumi_o), 64'(exp_yumi));
      if (g >= 0) checkOutput("pkt_data", 64'(dma_pkt_o), 64'(dma_pkt_i[g]));

      exp_ready = rdq.size() > 0 && dma_data_ready_i[rdq[0]];
      exp_dv = '0;
      if (rdq.size() > 0 && mem_data_v_i) exp_dv[rdq[0]] = 1'b1;
      checkOutput("fill_ready", 64'(mem_data_ready_o), 64'(exp_ready));
      checkOutput("fill_v", 64'(dma_data_v_o), 64'(exp_dv));
      for (int c = 0; c < N; c++) checkOutput("fill_bus", 64'(dma_data_o[c]), 64'(mem_data_i));

      exp_mv = wrq.size() > 0 && dma_data_v_i[wrq[0]];
      exp_dy = '0;
      if (wrq.size() > 0 && mem_data_yumi_i) exp_dy[wrq[0]] = 1'b1;
      checkOutput("evict_v", 64'(mem_data_v_o), 64'(exp_mv));
      checkOutput("evict_yumi", 64'(dma_data_yumi_o), 64'(exp_dy));
      if (exp_mv) checkOutput("evict_data", 64'(mem_data_o), 64'(dma_data_i[wrq[0]]));

      if (mem_data_v_i && mem_data_ready_o) begin
        any = 1'b0;
        for (int c = 0; c < N; c++)
          if (dma_data_v_o[c]) begin recv_q.push_back(c * 1000 + int'(dma_data_o[c])); any = 1'b1; end
        if (!any) recv_q.push_back(-1);
      end
      if (mem_data_v_o && mem_data_yumi_i) wb_q.push_back(int'(mem_data_o));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_i = 1'b1;
    dma_pkt_i = '0; dma_pkt_v_i = '0; dma_data_ready_i = '0; dma_data_i = '0; dma_data_v_i = '0;
    dma_pkt_yumi_i = 1'b0; mem_data_i = '0; mem_data_v_i = 1'b0; mem_data_yumi_i = 1'b0;
    repeat (2) tick();
    reset_i = 1'b0;

    @(negedge clk);
    checkOutput("reset_pkt_v", 64'(dma_pkt_v_o), 64'd0);
    checkOutput("reset_fill_ready", 64'(mem_data_ready_o), 64'd0);
    checkOutput("reset_evict_v", 64'(mem_data_v_o), 64'd0);
    tick();

    // Arbitration order 0,1,2 with downstream accepting every cycle.
    applyStimulus(0, 1, 0, 'h100);
    applyStimulus(1, 1, 0, 'h200);
    applyStimulus(2, 1, 0, 'h300);
    dma_pkt_yumi_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("arb_pkt", 64'(dma_pkt_o), 64'(mkPkt(0, 'h100 * (c + 1))));
      checkOutput("arb_yumi", 64'(dma_pkt_yumi_o), 64'(1 << c));
      tick();
      applyStimulus(c, 0, 0, 0);
    end
    dma_pkt_yumi_i = 1'b0;
    @(negedge clk);
    checkOutput("arb_idle", 64'(dma_pkt_v_o), 64'd0);
    checkOutput("model_rdq_len", 64'(rdq.size()), 64'd3);
    for (int j = 0; j < 3; j++) checkOutput("model_rdq", 64'(rdq[j]), 64'(j));
    tick();

    // Fill routing with a 5-cycle stall on cache 1 mid-block.
    dma_data_ready_i = '1;
    for (int w = 0; w < 24; w++) begin
      if (w == 12) begin
        dma_data_ready_i[1] = 1'b0;
        mem_data_v_i = 1'b1;
        mem_data_i = DW'(w);
        repeat (5) begin
          @(negedge clk);
          checkOutput("fill_bp_ready", 64'(mem_data_ready_o), 64'd0);
          tick();
        end
        dma_data_ready_i[1] = 1'b1;
      end
      mem_data_v_i = 1'b1;
      mem_data_i = DW'(w);
      tick();
    end
    mem_data_v_i = 1'b0;
    @(negedge clk);
    checkOutput("fill_done_ready", 64'(mem_data_ready_o), 64'd0);
    checkOutput("fill_count", 64'(recv_q.size()), 64'd24);
    for (int j = 0; j < recv_q.size() && j < 24; j++)
      checkOutput("fill_route", 64'(recv_q[j]), 64'((j / 8) * 1000 + j));
    checkOutput("model_rdq_empty", 64'(rdq.size()), 64'd0);
    tick();

    // Writeback from cache 3 with downstream yumi alternating 1,0.
    applyStimulus(3, 1, 1, 'h400);
    dma_pkt_yumi_i = 1'b1;
    @(negedge clk);
    checkOutput("wb_pkt", 64'(dma_pkt_o), 64'(mkPkt(1, 'h400)));
    checkOutput("wb_pkt_yumi", 64'(dma_pkt_yumi_o), 64'h8);
    tick();
    applyStimulus(3, 0, 1, 'h400);
    dma_pkt_yumi_i = 1'b0;
    dma_data_v_i[3] = 1'b1;
    begin
      int k;
      k = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
        dma_data_i[3] = DW'('hA0 + k);
        mem_data_yumi_i = (cyc % 2 == 0);
        @(negedge clk);
        checkOutput("wb_yumi", 64'(dma_data_yumi_o), 64'({mem_data_yumi_i, 3'b000}));
        tick();
        if (mem_data_yumi_i) k++;
      end
    end
    mem_data_yumi_i = 1'b0;
    @(negedge clk);
    checkOutput("wb_popped", 64'(mem_data_v_o), 64'd0);
    checkOutput("wb_count", 64'(wb_q.size()), 64'd8);
    for (int j = 0; j < wb_q.size() && j < 8; j++) checkOutput("wb_word", 64'(wb_q[j]), 64'('hA0 + j));
    tick();
    dma_data_v_i = '0;

    // Grant lock: cache 3 is held even though cache 0 now has priority.
    applyStimulus(3, 1, 0, 'h500);
    @(negedge clk);
    checkOutput("lock_first", 64'(dma_pkt_o), 64'(mkPkt(0, 'h500)));
    tick();
    applyStimulus(0, 1, 0, 'h600);
    repeat (3) begin
      @(negedge clk);
      checkOutput("lock_hold", 64'(dma_pkt_o), 64'(mkPkt(0, 'h500)));
      tick();
    end
    dma_pkt_yumi_i = 1'b1;
    @(negedge clk);
    checkOutput("lock_yumi", 64'(dma_pkt_yumi_o), 64'h8);
    tick();
    applyStimulus(3, 0, 0, 0);
    @(negedge clk);
    checkOutput("lock_wrap_pkt", 64'(dma_pkt_o), 64'(mkPkt(0, 'h600)));
    checkOutput("lock_wrap_yumi", 64'(dma_pkt_yumi_o), 64'h1);
    tick();
    applyStimulus(0, 0, 0, 0);
    dma_pkt_yumi_i = 1'b0;

    // Reset with reads outstanding, then fill the read FIFO.
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int c = 0; c < N; c++) applyStimulus(c, 1, 0, 'h1000 + c);
    dma_pkt_yumi_i = 1'b1;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      checkOutput("full_fill_yumi", 64'(dma_pkt_yumi_o), 64'(1 << c));
      tick();
      applyStimulus(c, 0, 0, 0);
    end
    dma_pkt_yumi_i = 1'b0;
    applyStimulus(1, 1, 0, 'h700);
    @(negedge clk);
    checkOutput("full_blocks_read", 64'(dma_pkt_v_o), 64'd0);
    tick();
    applyStimulus(2, 1, 1, 'h800);
    dma_pkt_yumi_i = 1'b1;
    @(negedge clk);
    checkOutput("full_write_pkt", 64'(dma_pkt_o), 64'(mkPkt(1, 'h800)));
    checkOutput("full_write_yumi", 64'(dma_pkt_yumi_o), 64'h4);
    tick();
    applyStimulus(2, 0, 1, 'h800);
    dma_pkt_yumi_i = 1'b0;
    @(negedge clk);
    checkOutput("full_still_blocked", 64'(dma_pkt_v_o), 64'd0);
    tick();

    applyStimulus(1, 0, 0, 0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    dma_data_v_i[2] = 1'b1;
    @(negedge clk);
    checkOutput("rst_pkt_v", 64'(dma_pkt_v_o), 64'd0);
    checkOutput("rst_fill_ready", 64'(mem_data_ready_o), 64'd0);
    checkOutput("rst_evict_v", 64'(mem_data_v_o), 64'd0);
    checkOutput("rst_evict_yumi", 64'(dma_data_yumi_o), 64'd0);
    tick();
    dma_data_v_i = '0;
    applyStimulus(2, 1, 0, 'h900);
    applyStimulus(3, 1, 0, 'hA00);
    dma_pkt_yumi_i = 1'b1;
    @(negedge clk);
    checkOutput("rst_first_grant", 64'(dma_pkt_yumi_o), 64'h4);
    checkOutput("rst_first_pkt", 64'(dma_pkt_o), 64'(mkPkt(0, 'h900)));
    tick();
    applyStimulus(2, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_second_grant", 64'(dma_pkt_yumi_o), 64'h8);
    tick();
    applyStimulus(3, 0, 0, 0);
    dma_pkt_yumi_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
